// File: rtl/rarp_rx_parser_if.sv
// rarp_rx_parser_if
//   Stream and result bundle for the RARP receive parser.
//   Input side : in_data / in_valid / in_last  -> in_ready (valid/ready beats)
//   Output side: out_valid + decoded ARP/RARP field set -> out_ready
//   master modport: the producer of beats and consumer of field sets.
//   slave modport : the parser itself.
interface rarp_rx_parser_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;

  logic              out_valid;
  logic              out_ready;
  logic [15:0]       hdr_type;
  logic [15:0]       proto_type;
  logic [7:0]        hdr_addr_length;
  logic [7:0]        pro_addr_length;
  logic [15:0]       operation;
  logic [47:0]       send_hdr_addr;
  logic [31:0]       send_ip_addr;
  logic [47:0]       target_hdr_addr;
  logic [31:0]       target_ip_addr;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_valid, hdr_type, proto_type, hdr_addr_length,
           pro_addr_length, operation, send_hdr_addr, send_ip_addr,
           target_hdr_addr, target_ip_addr
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_valid, hdr_type, proto_type, hdr_addr_length,
           pro_addr_length, operation, send_hdr_addr, send_ip_addr,
           target_hdr_addr, target_ip_addr
  );
endinterface

// File: rtl/rarp_rx_parser.sv
// rarp_rx_parser
//   Receives a 28-byte ARP/RARP payload as 224/DATA_W beats (network byte
//   order, first byte in the MSBs), checks length, header constants and
//   opcode, and presents one registered field set per good packet.
//   Bad packets raise a one-cycle err_pulse with a held err_code
//   (1 short, 2 long, 3 bad header, 4 bad opcode); long packets are drained
//   up to their in_last beat.
//
//   Ports:
//     clk, rst      clock and synchronous active-high reset
//     bus (slave)   input beat stream + output field set handshake
//     err_pulse     one-cycle pulse per rejected packet
//     err_code      code of the most recent rejection
//     pkt_cnt       good packets delivered   (RARP_STATS_EN only)
//     drop_cnt      rejected packets         (RARP_STATS_EN only)
//
//   Optional feature macro: RARP_STATS_EN adds the saturating statistics
//   counters and their CNT_W parameter.
module rarp_rx_parser #(
  parameter int DATA_W       = 32,
  parameter bit CHECK_OPCODE = 1'b1
`ifdef RARP_STATS_EN
  , parameter int CNT_W      = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  rarp_rx_parser_if.slave  bus,
  output logic             err_pulse,
  output logic [2:0]       err_code
`ifdef RARP_STATS_EN
  , output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0]   drop_cnt
`endif
);

  localparam int PKT_W = 224;
  localparam int WORDS = PKT_W / DATA_W;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  localparam logic [1:0] ST_RECV  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [2:0] ERR_SHORT = 3'd1;
  localparam logic [2:0] ERR_LONG  = 3'd2;
  localparam logic [2:0] ERR_HDR   = 3'd3;
  localparam logic [2:0] ERR_OP    = 3'd4;

  logic [1:0]              state;
  logic [IDX_W-1:0]        idx;
  // Only the bytes still needed are kept: the oldest DATA_W bits would be
  // shifted out by the final beat anyway.
  logic [PKT_W-DATA_W-1:0] shift_reg;
  logic [PKT_W-1:0]        pkt_next;
  logic                    beat_ok;
  logic                    hdr_bad;
  logic                    op_bad;

  logic                    out_valid_r;
  logic [15:0]             hdr_type_r;
  logic [15:0]             proto_type_r;
  logic [7:0]              hlen_r;
  logic [7:0]              plen_r;
  logic [15:0]             operation_r;
  logic [47:0]             sha_r;
  logic [31:0]             spa_r;
  logic [47:0]             tha_r;
  logic [31:0]             tpa_r;

  assign bus.in_ready = !rst && (state != ST_HOLD);
  assign beat_ok      = bus.in_valid && bus.in_ready;

  // Packet as it will look once the current beat is shifted in; on the
  // final beat this is the complete payload and is checked/loaded directly.
  assign pkt_next = {shift_reg, bus.in_data};

  assign hdr_bad = (pkt_next[223:208] != 16'h0001) ||
                   (pkt_next[207:192] != 16'h0800) ||
                   (pkt_next[191:184] != 8'd6)     ||
                   (pkt_next[183:176] != 8'd4);

  assign op_bad  = CHECK_OPCODE &&
                   (pkt_next[175:160] != 16'd3) &&
                   (pkt_next[175:160] != 16'd4);

  assign bus.out_valid       = out_valid_r;
  assign bus.hdr_type        = hdr_type_r;
  assign bus.proto_type      = proto_type_r;
  assign bus.hdr_addr_length = hlen_r;
  assign bus.pro_addr_length = plen_r;
  assign bus.operation       = operation_r;
  assign bus.send_hdr_addr   = sha_r;
  assign bus.send_ip_addr    = spa_r;
  assign bus.target_hdr_addr = tha_r;
  assign bus.target_ip_addr  = tpa_r;

  // Receive FSM: collect beats in RECV, classify on the last beat, park a
  // good field set in HOLD until consumed, swallow over-long packets in
  // DRAIN. Field registers only load on a good packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RECV;
      idx          <= '0;
      shift_reg    <= '0;
      out_valid_r  <= 1'b0;
      hdr_type_r   <= '0;
      proto_type_r <= '0;
      hlen_r       <= '0;
      plen_r       <= '0;
      operation_r  <= '0;
      sha_r        <= '0;
      spa_r        <= '0;
      tha_r        <= '0;
      tpa_r        <= '0;
      err_pulse    <= 1'b0;
      err_code     <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        ST_RECV: begin
          if (beat_ok) begin
            shift_reg <= pkt_next[PKT_W-DATA_W-1:0];
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (!bus.in_last) begin
                err_pulse <= 1'b1;
                err_code  <= ERR_LONG;
                state     <= ST_DRAIN;
              end else if (hdr_bad) begin
                err_pulse <= 1'b1;
                err_code  <= ERR_HDR;
              end else if (op_bad) begin
                err_pulse <= 1'b1;
                err_code  <= ERR_OP;
              end else begin
                hdr_type_r   <= pkt_next[223:208];
                proto_type_r <= pkt_next[207:192];
                hlen_r       <= pkt_next[191:184];
                plen_r       <= pkt_next[183:176];
                operation_r  <= pkt_next[175:160];
                sha_r        <= pkt_next[159:112];
                spa_r        <= pkt_next[111:80];
                tha_r        <= pkt_next[79:32];
                tpa_r        <= pkt_next[31:0];
                out_valid_r  <= 1'b1;
                state        <= ST_HOLD;
              end
            end else if (bus.in_last) begin
              idx       <= '0;
              err_pulse <= 1'b1;
              err_code  <= ERR_SHORT;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (beat_ok && bus.in_last) begin
            state <= ST_RECV;
          end
        end
        ST_HOLD: begin
          if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= ST_RECV;
          end
        end
        default: begin
          state <= ST_RECV;
        end
      endcase
    end
  end

`ifdef RARP_STATS_EN
  // Saturating statistics: a delivered packet is the out handshake, a drop
  // is counted from the registered err_pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if ((state == ST_HOLD) && out_valid_r && bus.out_ready && (pkt_cnt != '1)) begin
        pkt_cnt <= pkt_cnt + 1'b1;
      end
      if (err_pulse && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
